// File: rtl/multi_4bits_if.sv
// Operand/result bundle for the streaming array multiplier.
// Master drives operands, slave returns the registered product.
interface multi_4bits_if #(
  parameter int bits = 4
);
  logic [bits-1:0]   A;
  logic [bits-1:0]   B;
  logic [2*bits-1:0] Product;

  modport master (
    output A,
    output B,
    input  Product
  );

  modport slave (
    input  A,
    input  B,
    output Product
  );
endinterface

// File: rtl/multi_4bits.sv
// Two-stage unsigned array multiplier: operand regs, carry-save
// adder rows with a final ripple row, then the product register.
module multi_4bits #(
  parameter int bits = 4
) (
  input logic           clk,
  input logic           rst,
  multi_4bits_if.slave  io
);

  localparam int pw = 2 * bits;

  logic [bits-1:0] a_r;
  logic [bits-1:0] b_r;
  logic [pw-1:0]   sum;
  logic [pw-1:0]   prod_r;
  logic [bits-1:0] pp [bits];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r    <= '0;
      b_r    <= '0;
      prod_r <= '0;
    end else begin
      a_r    <= io.A;
      b_r    <= io.B;
      prod_r <= sum;
    end
  end

  assign io.Product = prod_r;

  for (genvar i = 0; i < bits; i++) begin : g_pp
    assign pp[i] = a_r & {bits{b_r[i]}};
  end

  // Row i, cell j sits at weight i+j; its carry is at weight i+j+1.
  for (genvar i = 0; i < bits; i++) begin : g_row
    for (genvar j = 0; j < bits; j++) begin : g_col
      logic s;
      logic c;
      if (i == 0) begin : g_init
        assign s = pp[0][j];
        assign c = 1'b0;
      end else if (j == bits - 1) begin : g_ha
        logic x;
        logic y;
        assign x = pp[i][j];
        assign y = g_row[i-1].g_col[j].c;
        assign s = x ^ y;
        assign c = x & y;
      end else begin : g_fa
        logic x;
        logic y;
        logic z;
        assign x = pp[i][j];
        assign y = g_row[i-1].g_col[j+1].s;
        assign z = g_row[i-1].g_col[j].c;
        assign s = x ^ y ^ z;
        assign c = (x & y) | (x & z) | (y & z);
      end
    end
    assign sum[i] = g_row[i].g_col[0].s;
  end

  // Ripple row merges the last sum and carry vectors into the upper half.
  for (genvar k = 0; k < bits; k++) begin : g_fin
    logic s;
    if (k == bits - 1) begin : g_last
      assign s = g_row[bits-1].g_col[k].c ^ g_fin[k-1].g_cy.co;
    end else begin : g_cy
      logic co;
      if (k == 0) begin : g_ha
        logic x;
        logic y;
        assign x  = g_row[bits-1].g_col[1].s;
        assign y  = g_row[bits-1].g_col[0].c;
        assign s  = x ^ y;
        assign co = x & y;
      end else begin : g_fa
        logic x;
        logic y;
        logic z;
        assign x  = g_row[bits-1].g_col[k+1].s;
        assign y  = g_row[bits-1].g_col[k].c;
        assign z  = g_fin[k-1].g_cy.co;
        assign s  = x ^ y ^ z;
        assign co = (x & y) | (x & z) | (y & z);
      end
    end
    assign sum[bits+k] = s;
  end

endmodule

// File: tb/tb_multi_4bits.sv
// Directed and streaming checks of multi_4bits at widths 4 and 8.
// Product is sampled on the falling edge or just after a rising one.
module tb_multi_4bits;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  multi_4bits_if #(.bits(4)) if4 ();
  multi_4bits_if #(.bits(8)) if8 ();

  multi_4bits #(.bits(4)) u4 (
    .clk (clk),
    .rst (rst),
    .io  (if4.slave)
  );

  multi_4bits #(.bits(8)) u8 (
    .clk (clk),
    .rst (rst),
    .io  (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  int da [4] = '{0, 1, 15, 8};
  int db [4] = '{7, 9, 15, 2};
  int dp [4] = '{0, 9, 225, 16};
  int sa [4] = '{2, 7, 15, 12};
  int sb [4] = '{3, 7, 1, 11};
  int sp [4] = '{6, 49, 15, 132};

  logic [15:0] q [$];

  initial begin
    rst    = 1'b1;
    if4.A  = '0;
    if4.B  = '0;
    if8.A  = '0;
    if8.B  = '0;
    repeat (2) @(negedge clk);
    check("rst4", 16'(if4.Product), 16'd0);
    check("rst8", 16'(if8.Product), 16'd0);

    rst   = 1'b0;
    if4.A = 4'd15;
    if4.B = 4'd15;
    repeat (2) @(negedge clk);
    check("pre_rst", 16'(if4.Product), 16'd225);

    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("rst_async", 16'(if4.Product), 16'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", 16'(if4.Product), 16'd0);
    end
    rst   = 1'b0;
    if4.A = 4'd3;
    if4.B = 4'd5;
    @(negedge clk);
    check("fill0", 16'(if4.Product), 16'd0);
    @(negedge clk);
    check("rel_3x5", 16'(if4.Product), 16'd15);

    for (int i = 0; i < 4; i++) begin
      if4.A = 4'(da[i]);
      if4.B = 4'(db[i]);
      repeat (2) @(negedge clk);
      check("dir", 16'(if4.Product), 16'(dp[i]));
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if4.A = 4'(a);
        if4.B = 4'(b);
        repeat (10) @(negedge clk);
        check("exh", 16'(if4.Product), 16'(a * b));
      end
    end

    if4.A = '0;
    if4.B = '0;
    repeat (2) @(negedge clk);
    if4.A = 4'(sa[0]);
    if4.B = 4'(sb[0]);
    @(negedge clk);
    check("lat0", 16'(if4.Product), 16'd0);
    if4.A = 4'(sa[1]);
    if4.B = 4'(sb[1]);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream", 16'(if4.Product), 16'(sp[i]));
      if (i + 2 < 4) begin
        if4.A = 4'(sa[i+2]);
        if4.B = 4'(sb[i+2]);
      end
    end

    if4.A = 4'd13;
    if4.B = 4'd14;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 check("stab_pos", 16'(if4.Product), 16'd182);
      @(negedge clk);
      check("stab_neg", 16'(if4.Product), 16'd182);
    end

    if4.A = 4'd9;
    if4.B = 4'd9;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("pulse", 16'(if4.Product), 16'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    if4.A = 4'd6;
    if4.B = 4'd7;
    @(negedge clk);
    check("pulse_flush", 16'(if4.Product), 16'd0);
    @(negedge clk);
    check("pulse_6x7", 16'(if4.Product), 16'd42);

    for (int i = 0; i < 1004; i++) begin
      int a;
      int b;
      @(negedge clk);
      if (q.size() == 2) begin
        logic [15:0] e;
        e = q.pop_front();
        check((i < 4) ? "m8_dir" : "m8_rand", 16'(if8.Product), e);
      end
      if (i < 1002) begin
        if (i == 0) begin
          a = 255;
          b = 255;
        end else if (i == 1) begin
          a = 128;
          b = 2;
        end else begin
          a = int'($urandom_range(0, 255));
          b = int'($urandom_range(0, 255));
        end
        if8.A = 8'(a);
        if8.B = 8'(b);
        q.push_back(16'(a * b));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_4bits.md
Name: multi_4bits

Overview:
- Parameterised unsigned integer multiplier: Product = A × B, full double-width result, no truncation.
- Fully pipelined, streaming: one new operand pair accepted every clock, fixed latency, no handshake.
- Stands alone as a datapath leaf; its top level is wired directly to operand sources and a result sink.

Parameters:
- bits, default 4: operand width in bits. Product width is 2*bits. Legal values are 2 to 16.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, asynchronous and active-high. Clears all pipeline registers immediately.
- A, input, bits: multiplicand, unsigned.
- B, input, bits: multiplier, unsigned.
- Product, output, 2*bits: unsigned A × B, registered.

Behaviour:
- Arithmetic:
  - Operands are unsigned.
  - Product = A*B exactly. The maximum (2^bits-1)^2 always fits in 2*bits; no overflow or saturation logic.
- Structure:
  - Stage 0: input registers A_r and B_r capture A and B on every rising edge.
  - Partial products: pp[i][j] = A_r[j] & B_r[i].
  - The partial products are reduced by an explicit array of half and full adders (carry-save rows plus a final ripple row), built with generate loops.
  - Stage 1: the final sum is registered into the Product register.
  - The "*" operator is not used for the datapath.
- Latency and throughput:
  - Operands sampled at rising edge N appear on Product after rising edge N+1. That is 2 register stages, one cycle after capture.
  - Throughput is one result per cycle; back-to-back changing operands are all honoured.
  - Product is constant between clock edges and depends only on registers, with no combinational path from A or B.
- Reset:
  - While rst=1: A_r, B_r and Product are 0, asynchronously, without waiting for a clock edge.
  - On rst deassertion: the first edge with rst=0 captures the operands; valid Product appears after the following edge.
  - Reset asserted mid-stream discards all in-flight results; nothing is recovered after release.
  - Before the pipeline fills after reset, Product reads 0 (0×0).
- Boundary conditions:
  - A=0 or B=0 gives 0.
  - A=1 gives B.
  - Maximum operands (all ones) give 2^(2*bits) - 2^(bits+1) + 1. For bits=4 this is 225.
  - Operands that hold stable for many cycles keep Product stable and correct indefinitely.
- X-handling: no X may propagate out of Product after reset when the inputs are driven to known values.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with A=15, B=15 in flight -> Product=0 immediately and stays 0 while rst=1. Release rst, hold A=3, B=5 -> Product=15 two edges later.
- Exhaustive, bits=4: all 256 (A,B) pairs, each held 10 cycles -> Product equals A*B for every pair. Checks include 0*7=0, 1*9=9, 15*15=225, 8*2=16.
- Streaming latency: apply A,B = (2,3), (7,7), (15,1), (12,11) on consecutive edges -> Product shows 6, 49, 15, 132 on consecutive cycles. The first result appears exactly one edge after its capture edge.
- Stability: hold A=13, B=14 for 20 cycles -> Product=182 every cycle with no glitch at clock edges.
- Parameter width, bits=8: A=255, B=255 -> Product=65025. A=128, B=2 -> Product=256. Random 1000 pairs match a reference model.
- Reset during fill: rst pulse of less than one clock period between two operand changes -> Product=0 during the pulse. The next result reflects only operands captured after release.
